// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - multi-cycle signed Booth multiply / non-restoring divide on one shared adder
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [5:0]       LAST    = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             prep_q, prep_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // u: Booth upper word / divide partial remainder; m: multiplier / dividend-quotient;
    // bb: Booth history bit / remainder bit 32
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             bb_q, bb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout, add_ovf;

    logic start, booth_sub, booth_add, div_sub, quot_neg, rem_msb;

    assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_sum  = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];
    assign add_ovf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    assign start     = ctrl_MULT | ctrl_DIV;
    assign booth_sub = m_q[0] & ~bb_q;
    assign booth_add = ~m_q[0] & bb_q;
    // Subtract |B| while the remainder is non-negative; a negative B flips add/sub.
    assign div_sub   = ~bb_q ^ b_q[WIDTH-1];
    assign quot_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign rem_msb   = u_q[WIDTH-1] ^ add_y[WIDTH-1] ^ add_cout;

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            RUN: begin
                if (prep_q) begin
                    add_x   = a_q[WIDTH-1] ? ~a_q : a_q;
                    add_cin = a_q[WIDTH-1];
                end else if (div_q) begin
                    add_x   = {u_q[WIDTH-2:0], m_q[WIDTH-1]};
                    add_y   = div_sub ? ~b_q : b_q;
                    add_cin = div_sub;
                end else begin
                    add_x   = u_q;
                    add_y   = booth_sub ? ~a_q : (booth_add ? a_q : '0);
                    add_cin = booth_sub;
                end
            end
            FIX: begin
                add_x   = ~m_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        div_d   = div_q;
        a_d     = a_q;
        b_d     = b_q;
        u_d     = u_q;
        m_d     = m_q;
        bb_d    = bb_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            RUN: begin
                if (prep_q) begin
                    prep_d = 1'b0;
                    if (div_q) m_d = add_sum;
                end else begin
                    if (div_q) begin
                        u_d  = add_sum;
                        bb_d = rem_msb;
                        m_d  = {m_q[WIDTH-2:0], ~rem_msb};
                    end else begin
                        // True sign of the step sum survives A = most-negative.
                        u_d  = {add_sum[WIDTH-1] ^ add_ovf, add_sum[WIDTH-1:1]};
                        m_d  = {add_sum[0], m_q[WIDTH-1:1]};
                        bb_d = m_q[0];
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (div_q) begin
                    if (b_q == '0) begin
                        res_d = '0;
                        exc_d = 1'b1;
                    end else begin
                        res_d = quot_neg ? add_sum : m_q;
                        exc_d = (a_q == MIN_NEG) && (b_q == {WIDTH{1'b1}});
                    end
                end else begin
                    res_d = m_q;
                    exc_d = (u_q != {WIDTH{m_q[WIDTH-1]}});
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            prep_d  = 1'b1;
            div_d   = ~ctrl_MULT;
            a_d     = data_operandA;
            b_d     = data_operandB;
            u_d     = '0;
            bb_d    = 1'b0;
            m_d     = ctrl_MULT ? data_operandB : data_operandA;
            res_d   = res_q;
            exc_d   = exc_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            div_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            u_q     <= '0;
            m_q     <= '0;
            bb_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            div_q   <= div_d;
            a_q     <= a_d;
            b_q     <= b_d;
            u_q     <= u_d;
            m_q     <= m_d;
            bb_q    <= bb_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
endmodule
